// File: rtl/serial_work_transmit_pkg.sv
// Shared timing constants and state encodings for the work-packet serial link.
// Both link ends import this so baud timing and packet size always agree.
package serial_work_transmit_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int PKT_BYTES        = 64;
    localparam int PKT_W            = PKT_BYTES * 8;
    localparam logic [5:0] LAST_BYTE = 6'(PKT_BYTES - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic {
        PKT_IDLE,
        PKT_RUN
    } pkt_state_e;

endpackage

// File: rtl/serial_work_transmit_tx_byte.sv
// UART 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
// A start request seen on the last stop-bit cycle chains the next byte with no gap.
module serial_work_transmit_tx_byte
    import serial_work_transmit_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       txd_o
);

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        txd_q, txd_d;
    logic        wrap;

    assign wrap   = (baud_q == BAUD_MAX);
    assign busy_o = (state_q != TX_IDLE);
    assign done_o = (state_q == TX_STOP) && wrap;
    assign txd_o  = txd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == TX_IDLE || wrap) ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        unique case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    state_d = TX_START;
                    sh_d    = byte_i;
                    txd_d   = 1'b0;
                end
            end
            TX_START: begin
                if (wrap) begin
                    state_d = TX_DATA;
                    bit_d   = 3'd0;
                    txd_d   = sh_q[0];
                end
            end
            TX_DATA: begin
                if (wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        txd_d = sh_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (wrap) begin
                    if (start_i) begin
                        state_d = TX_START;
                        sh_d    = byte_i;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/serial_work_transmit.sv
// Serialises one 512-bit work packet {midstate, data2} as 64 UART bytes,
// most significant byte first, feeding the byte transmitter back to back.
module serial_work_transmit
    import serial_work_transmit_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         send,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    output logic         busy,
    output logic         done,
    output logic         TxD
);

    pkt_state_e       st_q, st_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;
    logic [5:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tx_start, tx_busy, byte_done;
    logic [7:0]       tx_byte;

    assign busy = busy_q;
    assign done = done_q;

    serial_work_transmit_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .reset  (reset),
        .start_i(tx_start),
        .byte_i (tx_byte),
        .busy_o (tx_busy),
        .done_o (byte_done),
        .txd_o  (TxD)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= PKT_IDLE;
            pkt_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            pkt_q  <= pkt_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Next byte is offered on the last stop-bit cycle so there is no inter-byte gap.
    always_comb begin
        st_d     = st_q;
        pkt_d    = pkt_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tx_start = 1'b0;
        tx_byte  = pkt_q[PKT_W-9 -: 8];
        unique case (st_q)
            PKT_IDLE: begin
                if (send && !tx_busy) begin
                    st_d     = PKT_RUN;
                    pkt_d    = {midstate, data2};
                    idx_d    = 6'd0;
                    busy_d   = 1'b1;
                    tx_start = 1'b1;
                    tx_byte  = midstate[255:248];
                end
            end
            PKT_RUN: begin
                if (byte_done) begin
                    if (idx_q == LAST_BYTE) begin
                        st_d   = PKT_IDLE;
                        idx_d  = 6'd0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + 6'd1;
                        pkt_d    = {pkt_q[PKT_W-9:0], 8'h00};
                        tx_start = 1'b1;
                    end
                end
            end
            default: st_d = PKT_IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_work_transmit.sv
// Randomised self-checking bench: line waveform compared cycle by cycle
// against a model derived from the UART framing and byte order rules.
module tb_serial_work_transmit;

    localparam int CPB   = 4;
    localparam int FRAME = 640 * CPB;

    logic         clk = 1'b0;
    logic         reset, send;
    logic [255:0] midstate, data2;
    logic         busy, done, TxD;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [9:0] line0;
    int fstart[3];

    logic [511:0] pkt_a, pkt_b;

    always #5 clk = ~clk;

    serial_work_transmit #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset   (reset),
        .send    (send),
        .midstate(midstate),
        .data2   (data2),
        .busy    (busy),
        .done    (done),
        .TxD     (TxD)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Line level t cycles after the first start-bit cycle of a frame.
    function automatic logic exp_line(input logic [511:0] pkt, input int t);
        int pos, k, b;
        pos = t / CPB;
        k   = pos / 10;
        b   = pos % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return pkt[504 - 8 * k + (b - 1)];
    endfunction

    function automatic logic [511:0] rand_pkt();
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic start_frame(input logic [511:0] pkt, input bit hold);
        midstate = pkt[511:256];
        data2    = pkt[255:0];
        send     = 1'b1;
        tick();
        if (!hold) send = 1'b0;
    endtask

    task automatic run_frame(input logic [511:0] pkt, input int poke_at,
                             input int rst_at);
        for (int t = 0; t < FRAME; t++) begin
            if (t == rst_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("rst_txd", 64'(TxD), 64'd1);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                return;
            end
            chk("txd", 64'(TxD), 64'(exp_line(pkt, t)));
            chk("busy", 64'(busy), 64'd1);
            chk("done", 64'(done), 64'd0);
            if (t < 40 && t % CPB == 2) line0[t / CPB] = TxD;
            if (poke_at >= 0 && t == poke_at) begin
                send     = 1'b1;
                midstate = ~midstate;
            end else if (poke_at >= 0 && t == poke_at + 1) begin
                send = 1'b0;
            end
            tick();
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_txd", 64'(TxD), 64'd1);
    endtask

    initial begin
        pkt_a[511:256] = 256'h2b3f8126_0d2f6a9e_5b4f1c77_e8a2d3c1_9f60a4b3_71c8e5d2_04bb39fa_2619c0b5;
        pkt_a[255:0]   = 256'h80000000_00000000_39f3001b_6b7b8d4d_c14bfc31;
        reset    = 1'b1;
        send     = 1'b0;
        midstate = '0;
        data2    = '0;
        repeat (5) tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            chk("idle", 64'({TxD, busy, done}), 64'b100);
            tick();
        end

        start_frame(pkt_a, 1'b0);
        run_frame(pkt_a, -1, -1);
        chk("byte0_bits", 64'(line0), 64'b1001010110);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_txd", 64'(TxD), 64'd1);

        start_frame(pkt_a, 1'b0);
        run_frame(pkt_a, 100, -1);
        tick();

        pkt_b = rand_pkt();
        start_frame(pkt_b, 1'b0);
        run_frame(pkt_b, -1, 405);
        tick();
        chk("post_rst_idle", 64'({TxD, busy, done}), 64'b100);
        start_frame(pkt_a, 1'b0);
        run_frame(pkt_a, -1, -1);
        chk("rst_byte0", 64'(line0), 64'b1001010110);
        tick();

        pkt_b = rand_pkt();
        start_frame(pkt_b, 1'b1);
        for (int f = 0; f < 3; f++) begin
            fstart[f] = cyc;
            if (f == 2) send = 1'b0;
            run_frame(pkt_b, -1, -1);
            if (f < 2) tick();
        end
        chk("frame2_start", 64'(fstart[1] - fstart[0]), 64'(FRAME + 1));
        chk("frame3_start", 64'(fstart[2] - fstart[0]), 64'(2 * (FRAME + 1)));
        tick();

        for (int r = 0; r < 2; r++) begin
            pkt_b = rand_pkt();
            start_frame(pkt_b, 1'b0);
            run_frame(pkt_b, -1, -1);
            tick();
        end

        reset = 1'b1;
        send  = 1'b1;
        tick();
        reset = 1'b0;
        send  = 1'b0;
        chk("rst_beats_send", 64'({TxD, busy, done}), 64'b100);
        tick();
        chk("rst_beats_send2", 64'({TxD, busy, done}), 64'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
